// File: rtl/board_draw_scheduler.sv
// board_draw_scheduler
//   Sequences the per-tile glyph datapaths that draw the 4x4 sliding-puzzle
//   board. A full-board request draws tiles 0..15 in order. A move request
//   draws one tile. For each tile the block computes the screen origin, pulses
//   the glyph restart for one cycle, and then holds the glyph enable for
//   TILE_CYCLES cycles.
//
//   Optional feature (macro BLANK_SKIP_EN): adds blank_idx. A full redraw
//   skips the empty slot, and a move onto the empty slot completes without
//   drawing anything.
//
// Ports
//   clk           system clock, all logic on posedge
//   reset         synchronous, active-high
//   full_req      request redraw of all tiles (level, sampled each cycle)
//   move_req      request redraw of tile move_idx
//   move_idx[3:0] tile for move_req: row = idx[3:2], col = idx[1:0]
//   blank_idx[3:0] empty slot (BLANK_SKIP_EN only)
//   busy          high whenever the scheduler is not idle
//   done          one-cycle pulse when a request completes
//   tile_idx[3:0] tile currently being drawn
//   tile_x[7:0]   ORIGIN_X + col*TILE_W, feeds glyph xIn
//   tile_y[6:0]   ORIGIN_Y + row*TILE_H, feeds glyph yIn
//   glyph_enable  glyph datapath enable / VGA plot strobe
//   glyph_resetn  active-low restart of the glyph datapath
module board_draw_scheduler #(
    parameter int TILE_CYCLES = 81,
    parameter int TILE_W      = 30,
    parameter int TILE_H      = 30,
    parameter int ORIGIN_X    = 20,
    parameter int ORIGIN_Y    = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       full_req,
    input  logic       move_req,
    input  logic [3:0] move_idx,
`ifdef BLANK_SKIP_EN
    input  logic [3:0] blank_idx,
`endif
    output logic       busy,
    output logic       done,
    output logic [3:0] tile_idx,
    output logic [7:0] tile_x,
    output logic [6:0] tile_y,
    output logic       glyph_enable,
    output logic       glyph_resetn
);

    localparam int CNT_W = (TILE_CYCLES > 2) ? $clog2(TILE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TILE_CYCLES - 1);
    localparam logic [7:0] TILE_W8   = 8'(TILE_W);
    localparam logic [7:0] TILE_H8   = 8'(TILE_H);
    localparam logic [7:0] ORIGIN_X8 = 8'(ORIGIN_X);
    localparam logic [7:0] ORIGIN_Y8 = 8'(ORIGIN_Y);

    // The origin arithmetic is done at 8 bits and must never wrap.
    if (ORIGIN_X + 3 * TILE_W > 255) begin : gBadOriginX
        $error("board_draw_scheduler: ORIGIN_X + 3*TILE_W exceeds 255");
    end
    if (ORIGIN_Y + 3 * TILE_H > 127) begin : gBadOriginY
        $error("board_draw_scheduler: ORIGIN_Y + 3*TILE_H exceeds 127");
    end

    function automatic logic [7:0] originX(input logic [1:0] col);
        return 8'(ORIGIN_X8 + ({6'd0, col} * TILE_W8));
    endfunction

    function automatic logic [6:0] originY(input logic [1:0] row);
        return 7'(ORIGIN_Y8 + ({6'd0, row} * TILE_H8));
    endfunction

    typedef enum logic [2:0] {IDLE, LOAD, DRAW, NEXT, DONE} stateT;

    stateT            state, nextState;
    logic [CNT_W-1:0] cnt;
    logic             modeFull;
    logic             pendFull, pendMove;
    logic [3:0]       pendIdx;

    logic             startFull, startMove;
    logic [3:0]       startMoveIdx;
    logic [3:0]       firstFullIdx;
    logic [4:0]       nextFullIdx;    // bit 4 set: the full pass is finished
    logic             moveHitsBlank;
    logic [3:0]       tileIdxNext;

    logic             busyNext, doneNext, enableNext, resetnNext;
    logic [7:0]       tileXNext;
    logic [6:0]       tileYNext;

    // Request selection, only acted on in IDLE. Full always wins; a live
    // move request is newer than a pending one.
    always_comb begin
        startFull    = full_req || pendFull;
        startMove    = !startFull && (move_req || pendMove);
        startMoveIdx = move_req ? move_idx : pendIdx;
    end

`ifdef BLANK_SKIP_EN
    always_comb begin
        firstFullIdx  = (blank_idx == 4'd0) ? 4'd1 : 4'd0;
        moveHitsBlank = (startMoveIdx == blank_idx);
        nextFullIdx   = {1'b0, tile_idx} + 5'd1;
        if (nextFullIdx == {1'b0, blank_idx}) begin
            nextFullIdx = {1'b0, tile_idx} + 5'd2;
        end
    end
`else
    always_comb begin
        firstFullIdx  = 4'd0;
        moveHitsBlank = 1'b0;
        nextFullIdx   = {1'b0, tile_idx} + 5'd1;
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state and next tile index
    always_comb begin
        nextState   = state;
        tileIdxNext = tile_idx;
        case (state)
            IDLE: begin
                if (startFull) begin
                    nextState   = LOAD;
                    tileIdxNext = firstFullIdx;
                end else if (startMove) begin
                    nextState   = moveHitsBlank ? DONE : LOAD;
                    tileIdxNext = startMoveIdx;
                end
            end
            LOAD: nextState = DRAW;
            DRAW: begin
                if (cnt == CNT_LAST) begin
                    nextState = NEXT;
                end
            end
            NEXT: begin
                if (modeFull && !nextFullIdx[4]) begin
                    nextState   = LOAD;
                    tileIdxNext = nextFullIdx[3:0];
                end else begin
                    nextState = DONE;
                end
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        busyNext   = (nextState != IDLE);
        doneNext   = (nextState == DONE);
        enableNext = (nextState == DRAW);
        resetnNext = (nextState != LOAD);
        tileXNext  = tile_x;
        tileYNext  = tile_y;
        if (nextState == LOAD) begin
            tileXNext = originX(tileIdxNext[1:0]);
            tileYNext = originY(tileIdxNext[3:2]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy         <= 1'b0;
            done         <= 1'b0;
            glyph_enable <= 1'b0;
            glyph_resetn <= 1'b0;
            tile_idx     <= 4'd0;
            tile_x       <= 8'd0;
            tile_y       <= 7'd0;
        end else begin
            busy         <= busyNext;
            done         <= doneNext;
            glyph_enable <= enableNext;
            glyph_resetn <= resetnNext;
            tile_idx     <= tileIdxNext;
            tile_x       <= tileXNext;
            tile_y       <= tileYNext;
        end
    end

    // Draw counter, mode and one-deep pending requests
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            modeFull <= 1'b0;
            pendFull <= 1'b0;
            pendMove <= 1'b0;
        end else begin
            if (state == LOAD) begin
                cnt <= '0;
            end else if (state == DRAW) begin
                cnt <= cnt + 1'b1;
            end

            if (state == IDLE) begin
                if (startFull) begin
                    modeFull <= 1'b1;
                    pendFull <= 1'b0;
                    pendMove <= 1'b0;
                end else if (startMove) begin
                    modeFull <= 1'b0;
                    pendMove <= 1'b0;
                end
            end else begin
                if (full_req) begin
                    pendFull <= 1'b1;
                end
                if (move_req) begin
                    pendMove <= 1'b1;
                end
                // A queued full redraw covers any single tile.
                if (state == DONE && (pendFull || full_req)) begin
                    pendMove <= 1'b0;
                end
            end
        end
    end

    // Last move index seen while busy; only meaningful with pendMove set.
    always_ff @(posedge clk) begin
        if (state != IDLE && move_req) begin
            pendIdx <= move_idx;
        end
    end

endmodule
